rr_sel_arbiter4: RTL and testbench
==================================

Name: rr_sel_arbiter4

Overview:
- Round-robin arbiter for four 32-bit sources sharing one 32-bit 4:1 datapath mux.
- Sits directly upstream of the mux and generates its registered 2-bit select.
- Presents the muxed word to a single consumer with a valid/ready handshake.
- Returns a one-hot grant pulse to the winning source when the consumer accepts the transfer.

Parameters:
- PTR_INIT, 0, reset value of the round-robin priority pointer (0..3).
- BACK2BACK, 1, if 1, a new winner is loaded in the same cycle a transfer completes; if 0, one idle cycle is inserted between transfers.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  per-source request; bit i means source i's data on mux input i+1 is valid.
- out_ready  input  1  consumer can accept this cycle.
- sel  output  2  registered select to the 32-bit 4:1 mux; 00 picks input 1, 11 picks input 4.
- out_valid  output  1  muxed word is valid for the consumer.
- gnt  output  4  one-hot, combinational; pulses for exactly the cycle the transfer completes.
- busy  output  1  high in the BUSY state.

Behaviour:
- Reset (sync, active-high), values taken on the next edge:
  - state=IDLE, sel=2'b00, out_valid=0, gnt=4'b0000, busy=0, ptr=PTR_INIT.
- Reset overrides everything, including a transfer in flight. No gnt is issued for an aborted transfer.
- Priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4. The winner is the first index with req set.
- States:
  - IDLE:
    - If req==0: stay in IDLE; sel holds its last value.
    - Else: sel<=winner and state<=BUSY.
    - Latency: req rises at edge k, so out_valid=1 from edge k+1.
  - BUSY:
    - out_valid=1 and busy=1; sel is stable for the whole state.
    - A transfer completes in a cycle with out_valid&&out_ready. That cycle: gnt[sel]=1, and ptr<=sel+1 (wraps 3->0).
    - After completion with BACK2BACK=1: pick the next winner from req masked by ~gnt, using the new ptr order. If one exists, sel<=next winner and stay BUSY. Otherwise go to IDLE.
    - After completion with BACK2BACK=0: always go to IDLE.
    - No completion (out_ready=0): hold everything. Winner changes and new requests are ignored.
- gnt is 0 in every cycle without a completion. It never has more than one bit set.
- Sources keep req and data stable until their gnt pulse. If req[sel] drops while in BUSY, the transfer still completes and gnt still pulses; no abort.
- Simultaneous requests from all four sources with out_ready tied high and BACK2BACK=1:
  - Grants rotate ptr-first at one transfer per cycle.
  - No source waits more than 3 transfers.
- Widths: ptr is 2 bits; sel+1 uses natural 2-bit wrap.

Optional Feature:
- ARB_GRANT_CNT_EN
- Defined:
  - Adds output grant_count [15:0], cleared by reset.
  - Increments by 1 on every completed transfer and wraps 16'hFFFF->0.
  - Adds output last_src [1:0], which captures sel at each completion (reset 0).
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Reset with PTR_INIT=0 and req=4'b0000 for 3 cycles -> sel=00, out_valid=0, gnt=0, busy=0 throughout.
- Single request: req=4'b0100 at edge 1, out_ready=1 -> edge 2: sel=10, out_valid=1. In that cycle gnt=4'b0100. ptr becomes 3, then state returns to IDLE.
- Round-robin rotation: req=4'b1111 held, out_ready=1, BACK2BACK=1 -> sel sequence 00,01,10,11,00 on consecutive cycles. gnt follows as 0001,0010,0100,1000,0001.
- Backpressure: req=4'b0011, out_ready=0 for 5 cycles -> sel=00 stable, out_valid=1, gnt=0. When out_ready rises: gnt=0001 that cycle, then sel=01 next cycle.
- BACK2BACK=0 with req=4'b1001 and ptr=3 -> first grant gnt=1000, then one cycle with out_valid=0, then sel=00 and gnt=0001.
- Reset mid-transfer: BUSY with sel=10 and out_ready=0; assert reset for 1 cycle -> next edge: out_valid=0, sel=00, ptr=PTR_INIT, no gnt pulse. With ARB_GRANT_CNT_EN, grant_count=0.

Source files
------------

// File: rtl/rr_sel_arbiter4.sv
// Four-source round-robin arbiter that drives the registered select of a 4:1 datapath mux.
// Build with ARB_GRANT_CNT_EN defined to add the grant_count / last_src observability ports.
module rr_sel_arbiter4 #(
  parameter int PTR_INIT  = 0,
  parameter int BACK2BACK = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic [3:0] gnt,
  output logic       busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [15:0] grant_count,
  output logic [1:0]  last_src
`endif
);

  localparam logic [1:0] PTR_RST = PTR_INIT[1:0];

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] ptr_nxt;
  logic [3:0] sel_oh;
  logic       fire;
  logic [2:0] idle_pick;
  logic [2:0] next_pick;

  // Returns {found, index}: the first set bit of v scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [2:0] pick(input logic [3:0] v, input logic [1:0] p);
    logic [3:0] rot;
    logic [1:0] off;
    logic       found;
    rot   = 4'({v, v} >> p);
    found = 1'b1;
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: begin
        off   = 2'd0;
        found = 1'b0;
      end
    endcase
    return {found, 2'(p + off)};
  endfunction

  assign sel_oh    = 4'b0001 << sel;
  assign fire      = out_valid && out_ready && !reset;
  assign gnt       = fire ? sel_oh : 4'b0000;
  assign ptr_nxt   = sel + 2'd1;
  assign idle_pick = pick(req, ptr);
  assign next_pick = pick(req & ~sel_oh, ptr_nxt);

  // Control state: winner selection, pointer rotation and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 2'b00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ptr       <= PTR_RST;
    end else begin
      case (state)
        IDLE: begin
          if (idle_pick[2]) begin
            sel       <= idle_pick[1:0];
            state     <= BUSY;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        BUSY: begin
          if (out_ready) begin
            ptr <= ptr_nxt;
            if (BACK2BACK != 0 && next_pick[2]) begin
              sel <= next_pick[1:0];
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_GRANT_CNT_EN
  // Completion bookkeeping; counter wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count <= 16'd0;
      last_src    <= 2'b00;
    end else if (fire) begin
      grant_count <= grant_count + 16'd1;
      last_src    <= sel;
    end
  end
`endif

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Bench for rr_sel_arbiter4: two instances (back-to-back with PTR_INIT=0, idle-gap with PTR_INIT=3)
// checked every cycle against a transaction-level round-robin model plus directed literal checks.
module tb_rr_sel_arbiter4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       rdy;

  logic [1:0] sel_d  [2];
  logic       ov_d   [2];
  logic [3:0] gnt_d  [2];
  logic       busy_d [2];
`ifdef ARB_GRANT_CNT_EN
  logic [15:0] cnt_d  [2];
  logic [1:0]  last_d [2];
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: is a transfer outstanding, which source owns it, rotation start
  bit m_act  [2];
  int m_sel  [2];
  int m_ptr  [2];
  int m_cnt  [2];
  int m_last [2];
  int pinit  [2] = '{0, 3};
  bit b2b    [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  rr_sel_arbiter4 #(.PTR_INIT(0), .BACK2BACK(1)) u_a (
    .clk(clk), .reset(reset), .req(req), .out_ready(rdy),
    .sel(sel_d[0]), .out_valid(ov_d[0]), .gnt(gnt_d[0]), .busy(busy_d[0])
`ifdef ARB_GRANT_CNT_EN
    , .grant_count(cnt_d[0]), .last_src(last_d[0])
`endif
  );

  rr_sel_arbiter4 #(.PTR_INIT(3), .BACK2BACK(0)) u_b (
    .clk(clk), .reset(reset), .req(req), .out_ready(rdy),
    .sel(sel_d[1]), .out_valid(ov_d[1]), .gnt(gnt_d[1]), .busy(busy_d[1])
`ifdef ARB_GRANT_CNT_EN
    , .grant_count(cnt_d[1]), .last_src(last_d[1])
`endif
  );

  function automatic int win(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i]  <= 1'b0;
        m_sel[i]  <= 0;
        m_ptr[i]  <= pinit[i];
        m_cnt[i]  <= 0;
        m_last[i] <= 0;
      end else if (m_act[i]) begin
        if (rdy) begin
          m_ptr[i]  <= (m_sel[i] + 1) % 4;
          m_cnt[i]  <= (m_cnt[i] + 1) % 65536;
          m_last[i] <= m_sel[i];
          if (b2b[i] && win(req & ~(4'b0001 << m_sel[i]), (m_sel[i] + 1) % 4) >= 0)
            m_sel[i] <= win(req & ~(4'b0001 << m_sel[i]), (m_sel[i] + 1) % 4);
          else
            m_act[i] <= 1'b0;
        end
      end else if (req != 4'b0000) begin
        m_sel[i] <= win(req, m_ptr[i]);
        m_act[i] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] got, exp;
        logic [3:0] eg;
        eg  = (m_act[i] && rdy && !reset) ? (4'b0001 << m_sel[i]) : 4'b0000;
        exp = {2'(m_sel[i]), m_act[i], eg, m_act[i]};
        got = {sel_d[i], ov_d[i], gnt_d[i], busy_d[i]};
        n_cmp++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL model[%0d] t=%0t {sel,valid,gnt,busy} got %b expected %b", i, $time, got, exp);
        end
`ifdef ARB_GRANT_CNT_EN
        n_cmp++;
        if (cnt_d[i] !== 16'(m_cnt[i]) || last_d[i] !== 2'(m_last[i])) begin
          n_fail++;
          $display("FAIL count[%0d] t=%0t got cnt=%0d last=%0d expected cnt=%0d last=%0d",
                   i, $time, cnt_d[i], last_d[i], m_cnt[i], m_last[i]);
        end
`endif
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    rdy   = 1'b0;
    cyc();
    chk_en = 1'b1;

    // Reset held with no requests
    for (int c = 0; c < 3; c++) begin
      look();
      chk("rst_sel",  32'(sel_d[0]),  32'd0);
      chk("rst_vld",  32'(ov_d[0]),   32'd0);
      chk("rst_gnt",  32'(gnt_d[0]),  32'd0);
      chk("rst_busy", 32'(busy_d[0]), 32'd0);
      cyc();
    end

    // Single request from source 2
    reset = 1'b0; req = 4'b0100; rdy = 1'b1;
    look();
    chk("single_pre_vld", 32'(ov_d[0]), 32'd0);
    cyc();
    look();
    chk("single_sel", 32'(sel_d[0]), 32'd2);
    chk("single_vld", 32'(ov_d[0]),  32'd1);
    chk("single_gnt", 32'(gnt_d[0]), 32'b0100);
    cyc(); req = 4'b0000;
    look();
    chk("single_idle", 32'(ov_d[0]), 32'd0);

    // Pointer now 3 in both: idle-gap instance serves 3, idles, then 0
    cyc(); req = 4'b1001;
    look();
    cyc();
    look();
    chk("gap_sel1", 32'(sel_d[1]), 32'd3);
    chk("gap_gnt1", 32'(gnt_d[1]), 32'b1000);
    chk("b2b_gnt1", 32'(gnt_d[0]), 32'b1000);
    cyc(); req = 4'b0001;
    look();
    chk("gap_idle", 32'(ov_d[1]),  32'd0);
    chk("gap_ngnt", 32'(gnt_d[1]), 32'd0);
    chk("b2b_sel2", 32'(sel_d[0]), 32'd0);
    cyc();
    look();
    chk("gap_sel2", 32'(sel_d[1]), 32'd0);
    chk("gap_gnt2", 32'(gnt_d[1]), 32'b0001);
    cyc(); req = 4'b0000;
    look();
    cyc();
    look();

    // Full rotation with all sources requesting
    cyc(); reset = 1'b1;
    look();
    cyc(); reset = 1'b0; req = 4'b1111; rdy = 1'b1;
    look();
    for (int k = 0; k < 5; k++) begin
      cyc();
      look();
      chk("rot_sel", 32'(sel_d[0]), 32'(k % 4));
      chk("rot_gnt", 32'(gnt_d[0]), 32'(4'b0001 << (k % 4)));
    end

    // Backpressure
    cyc(); reset = 1'b1; req = 4'b0000; rdy = 1'b0;
    look();
    cyc(); reset = 1'b0; req = 4'b0011;
    look();
    for (int k = 0; k < 5; k++) begin
      cyc();
      look();
      chk("bp_sel", 32'(sel_d[0]), 32'd0);
      chk("bp_vld", 32'(ov_d[0]),  32'd1);
      chk("bp_gnt", 32'(gnt_d[0]), 32'd0);
    end
    cyc(); rdy = 1'b1;
    look();
    chk("bp_rel_gnt", 32'(gnt_d[0]), 32'b0001);
    cyc(); req = 4'b0010;
    look();
    chk("bp_next_sel", 32'(sel_d[0]), 32'd1);
    cyc(); req = 4'b0000;
    look();

    // Reset aborting a stalled transfer, then pointer must restart from PTR_INIT
    cyc(); reset = 1'b1; rdy = 1'b0;
    look();
    cyc(); reset = 1'b0; req = 4'b0100;
    look();
    cyc();
    look();
    chk("abort_busy_sel", 32'(sel_d[0]), 32'd2);
    cyc(); reset = 1'b1; rdy = 1'b1;
    look();
    chk("abort_gnt", 32'(gnt_d[0]), 32'd0);
    cyc(); reset = 1'b0; req = 4'b0000; rdy = 1'b0;
    look();
    chk("abort_vld", 32'(ov_d[0]),  32'd0);
    chk("abort_sel", 32'(sel_d[0]), 32'd0);
    chk("abort_gnt2", 32'(gnt_d[0]), 32'd0);
`ifdef ARB_GRANT_CNT_EN
    chk("abort_cnt", 32'(cnt_d[0]), 32'd0);
`endif
    cyc(); req = 4'b1111; rdy = 1'b1;
    look();
    cyc();
    look();
    chk("ptr_init_a", 32'(gnt_d[0]), 32'b0001);
    chk("ptr_init_b", 32'(gnt_d[1]), 32'b1000);

    // Random traffic under the model
    for (int c = 0; c < 300; c++) begin
      cyc();
      reset = ($urandom_range(0, 49) == 0);
      req   = 4'($urandom);
      rdy   = 1'($urandom);
      look();
    end

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
